// File: rtl/alu_op_issuer.sv
// Issues one command at a time to an external combinational ALU and returns the result.
// Keeps an accumulator as the first operand and counts completed responses.
`timescale 1ns/1ps
module alu_op_issuer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_operand,
    input  logic         cmd_wb,
    output logic [N-1:0] alu_dataa,
    output logic [N-1:0] alu_datab,
    output logic [2:0]   alu_selop,
    input  logic [N-1:0] alu_result,
    input  logic         alu_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_cout,
    output logic [N-1:0] acc,
    output logic [15:0]  op_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [N-1:0]       dataa_q, dataa_d;
    logic [N-1:0]       datab_q, datab_d;
    logic [2:0]         selop_q, selop_d;
    logic               wb_q, wb_d;
    logic [N-1:0]       rsp_result_q, rsp_result_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic [N-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    // Next-state and datapath updates; handshake flags are registered from the next state.
    always_comb begin
        state_d      = state_q;
        dataa_d      = dataa_q;
        datab_d      = datab_q;
        selop_d      = selop_q;
        wb_d         = wb_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        acc_d        = acc_q;
        op_count_d   = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    selop_d = cmd_op;
                    datab_d = cmd_operand;
                    dataa_d = acc_q;
                    wb_d    = cmd_wb;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rsp_result_d = alu_result;
                rsp_cout_d   = alu_cout;
                if (wb_q) begin
                    acc_d = alu_result;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            dataa_q      <= '0;
            datab_q      <= '0;
            selop_q      <= 3'b000;
            wb_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            acc_q        <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            rsp_valid_q  <= rsp_valid_d;
            dataa_q      <= dataa_d;
            datab_q      <= datab_d;
            selop_q      <= selop_d;
            wb_q         <= wb_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            acc_q        <= acc_d;
            op_count_q   <= op_count_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign alu_dataa  = dataa_q;
    assign alu_datab  = datab_q;
    assign alu_selop  = selop_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign acc        = acc_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer driving a behavioural 8-bit ALU.
`timescale 1ns/1ps
module tb_alu_op_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wb;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_operand;
    logic [7:0]  alu_dataa, alu_datab, alu_result;
    logic [2:0]  alu_selop;
    logic        alu_cout;
    logic        rsp_valid, rsp_ready, rsp_cout;
    logic [7:0]  rsp_result, acc;
    logic [15:0] op_count;

    int          tests = 0;
    int          fails = 0;
    logic [8:0]  sb_q[$];
    logic [7:0]  acc_m;
    logic [15:0] cnt_m;

    always #5 clk = ~clk;

    // Reference ALU: returns {cout, result}
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  alu_f = {1'b0, b};
            3'b001:  alu_f = {1'b0, ~b};
            3'b010:  alu_f = {1'b0, a & b};
            3'b011:  alu_f = {1'b0, a | b};
            3'b100:  alu_f = {1'b0, a ^ b};
            3'b101:  alu_f = {1'b0, a} + {1'b0, b};
            3'b110:  alu_f = {1'b0, b} + 9'd1;
            default: alu_f = {1'b0, ~b} + 9'd1;
        endcase
    endfunction

    assign {alu_cout, alu_result} = alu_f(alu_selop, alu_dataa, alu_datab);

    alu_op_issuer #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_operand(cmd_operand), .cmd_wb(cmd_wb),
        .alu_dataa(alu_dataa), .alu_datab(alu_datab), .alu_selop(alu_selop),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .acc(acc), .op_count(op_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command until accepted; returns just after the accepting edge with the expectation queued.
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] b, input logic wb, output logic ok);
        int n;
        logic [8:0] r;
        n = 0;
        cmd_op = op; cmd_operand = b; cmd_wb = wb; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        ok = cmd_ready;
        if (ok) begin
            tick();
            r = alu_f(op, acc_m, b);
            sb_q.push_back(r);
            if (wb) acc_m = r[7:0];
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cnt_m = cnt_m + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({acc, alu_dataa, alu_datab, rsp_result} !== 32'h0) begin
            fails++; $display("FAIL reset_data got=%h exp=0", {acc, alu_dataa, alu_datab, rsp_result});
        end
        tests++;
        if ({alu_selop, rsp_cout, rsp_valid, op_count} !== 21'h0) begin
            fails++; $display("FAIL reset_ctrl got=%h exp=0", {alu_selop, rsp_cout, rsp_valid, op_count});
        end
        rst = 1'b0;
        acc_m = 8'h00; cnt_m = 16'h0000; sb_q.delete();
        tick();
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_pass_b();
        logic ok; int lat; logic [8:0] e;
        send_cmd(3'b000, 8'h5A, 1'b1, ok);
        wait_rsp(lat);
        tests++;
        if (!ok || lat != 1) begin
            fails++; $display("FAIL pass_latency got=%0d exp=1 ok=%b", lat, ok);
        end
        e = sb_q.pop_front();
        tests++;
        if ({rsp_cout, rsp_result} !== e || rsp_result !== 8'h5A) begin
            fails++; $display("FAIL pass_result got=%h exp=%h", {rsp_cout, rsp_result}, e);
        end
        handshake();
        tests++;
        if (acc !== acc_m || acc !== 8'h5A || op_count !== 16'd1) begin
            fails++; $display("FAIL pass_state got acc=%h cnt=%h exp acc=5a cnt=1", acc, op_count);
        end
    endtask

    task automatic test_add();
        logic ok; int lat; logic [8:0] e;
        send_cmd(3'b101, 8'hC0, 1'b1, ok);
        tests++;
        if (!ok || alu_dataa !== 8'h5A || alu_selop !== 3'b101 || alu_datab !== 8'hC0) begin
            fails++; $display("FAIL add_operands got a=%h b=%h op=%h exp a=5a b=c0 op=5", alu_dataa, alu_datab, alu_selop);
        end
        wait_rsp(lat);
        e = sb_q.pop_front();
        tests++;
        if ({rsp_cout, rsp_result} !== e || {rsp_cout, rsp_result} !== 9'h11A || acc !== 8'h1A) begin
            fails++; $display("FAIL add_result got=%h acc=%h exp=%h acc=1a", {rsp_cout, rsp_result}, acc, e);
        end
        handshake();
    endtask

    task automatic test_inc_nowb();
        logic ok; int lat; logic [8:0] e;
        send_cmd(3'b110, 8'hFF, 1'b0, ok);
        wait_rsp(lat);
        e = sb_q.pop_front();
        tests++;
        if (!ok || {rsp_cout, rsp_result} !== e || {rsp_cout, rsp_result} !== 9'h100) begin
            fails++; $display("FAIL inc_result got=%h exp=%h", {rsp_cout, rsp_result}, e);
        end
        handshake();
        tests++;
        if (acc !== acc_m || acc !== 8'h1A || op_count !== 16'd3) begin
            fails++; $display("FAIL inc_nowb got acc=%h cnt=%h exp acc=1a cnt=3", acc, op_count);
        end
    endtask

    task automatic test_backpressure();
        logic ok; int lat; logic [8:0] e; logic [8:0] held; logic [18:0] alu_s;
        send_cmd(3'b010, 8'h0F, 1'b1, ok);
        wait_rsp(lat);
        held = {rsp_cout, rsp_result};
        alu_s = {alu_dataa, alu_datab, alu_selop};
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_operand = 8'($urandom_range(255, 0));
            cmd_op = 3'($urandom_range(7, 0));
            tick();
            tests++;
            if (rsp_valid !== 1'b1 || {rsp_cout, rsp_result} !== held || cmd_ready !== 1'b0
                || {alu_dataa, alu_datab, alu_selop} !== alu_s) begin
                fails++; $display("FAIL bp_hold cyc=%0d got v=%b r=%h rdy=%b alu=%h exp v=1 r=%h rdy=0 alu=%h",
                                  i, rsp_valid, {rsp_cout, rsp_result}, cmd_ready,
                                  {alu_dataa, alu_datab, alu_selop}, held, alu_s);
            end
        end
        cmd_valid = 1'b0;
        e = sb_q.pop_front();
        tests++;
        if (held !== e) begin
            fails++; $display("FAIL bp_result got=%h exp=%h", held, e);
        end
        handshake();
        tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || {rsp_cout, rsp_result} !== e) begin
            fails++; $display("FAIL bp_release got rdy=%b v=%b r=%h exp rdy=1 v=0 r=%h", cmd_ready, rsp_valid, {rsp_cout, rsp_result}, e);
        end
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        tests++;
        if (op_count !== cnt_m || acc !== acc_m || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL idle_ready got cnt=%h acc=%h exp cnt=%h acc=%h", op_count, acc, cnt_m, acc_m);
        end
    endtask

    task automatic test_logic_ops();
        logic ok; int lat; logic [8:0] e;
        logic [2:0] ops[5];
        logic [7:0] bs[5];
        ops = '{3'b001, 3'b011, 3'b100, 3'b111, 3'b111};
        bs  = '{8'h3C, 8'hA5, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 5; i++) begin
            send_cmd(ops[i], bs[i], 1'(i % 2), ok);
            wait_rsp(lat);
            e = sb_q.pop_front();
            tests++;
            if (!ok || lat != 1 || {rsp_cout, rsp_result} !== e || acc !== acc_m) begin
                fails++; $display("FAIL logic_op%0d got=%h acc=%h lat=%0d exp=%h acc=%h", ops[i], {rsp_cout, rsp_result}, acc, lat, e, acc_m);
            end
            handshake();
        end
    endtask

    task automatic test_reset_abort();
        logic ok;
        rst = 1'b1; tick(); rst = 1'b0;
        acc_m = 8'h00; cnt_m = 16'h0000; sb_q.delete();
        tick();
        send_cmd(3'b101, 8'h80, 1'b1, ok);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (!ok || {acc, alu_dataa, alu_datab, rsp_result, alu_selop, rsp_cout, rsp_valid, op_count} !== 53'h0) begin
            fails++; $display("FAIL abort_clear got acc=%h a=%h b=%h r=%h op=%h c=%b v=%b cnt=%h exp all 0",
                              acc, alu_dataa, alu_datab, rsp_result, alu_selop, rsp_cout, rsp_valid, op_count);
        end
        cmd_valid = 1'b1; cmd_op = 3'b011; cmd_operand = 8'h77; cmd_wb = 1'b1;
        tick();
        tick();
        cmd_valid = 1'b0;
        rst = 1'b0;
        sb_q.delete();
        acc_m = 8'h00;
        tests++;
        if (alu_datab !== 8'h00 || alu_selop !== 3'b000) begin
            fails++; $display("FAIL abort_no_accept got b=%h op=%h exp b=0 op=0", alu_datab, alu_selop);
        end
        repeat (4) tick();
        tests++;
        if (rsp_valid !== 1'b0 || acc !== 8'h00 || op_count !== 16'h0000 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL abort_after got v=%b acc=%h cnt=%h rdy=%b exp v=0 acc=0 cnt=0 rdy=1", rsp_valid, acc, op_count, cmd_ready);
        end
    endtask

    // Streams commands with both sides always ready, starting just below the counter wrap point.
    task automatic test_back_to_back();
        int cyc, last, done, accepts;
        logic acc_now, cmp_now, saw_wrap;
        logic [8:0] e, r;
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        cnt_m = 16'hFFFE;
        cyc = 0; last = -1; done = 0; accepts = 0; saw_wrap = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'($urandom_range(7, 0)); cmd_operand = 8'($urandom_range(255, 0)); cmd_wb = 1'($urandom_range(1, 0));
        while (done < 6 && cyc < 60) begin
            acc_now = cmd_valid && cmd_ready;
            cmp_now = rsp_valid && rsp_ready;
            if (cmp_now) begin
                e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
                tests++;
                if ({rsp_cout, rsp_result} !== e) begin
                    fails++; $display("FAIL b2b_result got=%h exp=%h", {rsp_cout, rsp_result}, e);
                end
            end
            if (acc_now) begin
                if (last >= 0) begin
                    tests++;
                    if (cyc - last != 3) begin
                        fails++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - last);
                    end
                end
                last = cyc;
                accepts++;
                r = alu_f(cmd_op, acc_m, cmd_operand);
                sb_q.push_back(r);
                if (cmd_wb) acc_m = r[7:0];
            end
            tick();
            cyc++;
            if (acc_now) begin
                cmd_op = 3'($urandom_range(7, 0));
                cmd_operand = 8'($urandom_range(255, 0));
                cmd_wb = 1'($urandom_range(1, 0));
            end
            if (cmp_now) begin
                done++;
                cnt_m = cnt_m + 16'd1;
                if (cnt_m == 16'h0000) saw_wrap = 1'b1;
                tests++;
                if (op_count !== cnt_m || acc !== acc_m) begin
                    fails++; $display("FAIL b2b_count got cnt=%h acc=%h exp cnt=%h acc=%h", op_count, acc, cnt_m, acc_m);
                end
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tests++;
        if (done != 6 || !saw_wrap || op_count !== 16'h0004) begin
            fails++; $display("FAIL b2b_total got done=%0d cnt=%h exp done=6 cnt=0004", done, op_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 3'b000; cmd_operand = 8'h00; cmd_wb = 1'b0;
        rsp_ready = 1'b0;
        acc_m = 8'h00; cnt_m = 16'h0000;
        test_reset();
        test_pass_b();
        test_add();
        test_inc_nowb();
        test_backpressure();
        test_logic_ops();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
